// File: rtl/ioshim_memio_arb_if.sv
// Requester-side and memio-side signal bundle for the ioshim memio arbiter.
// master = arbiter view; slave = requesters plus the ioshim_cpu memio port.
interface ioshim_memio_arb_if #(
    parameter int unsigned NREQ = 2
);
    logic [NREQ-1:0]    req_rd;
    logic [2*NREQ-1:0]  req_wr;
    logic [11*NREQ-1:0] req_addr;
    logic [16*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]    req_done;
    logic [NREQ-1:0]    req_err;
    logic [15:0]        req_rdata;
    logic               m_rd;
    logic [1:0]         m_wr;
    logic [10:0]        m_addr;
    logic [15:0]        m_wdata;
    logic [15:0]        m_rdata;
    logic               m_done;

    modport master (
        input  req_rd, req_wr, req_addr, req_wdata, m_rdata, m_done,
        output req_done, req_err, req_rdata, m_rd, m_wr, m_addr, m_wdata
    );

    modport slave (
        output req_rd, req_wr, req_addr, req_wdata, m_rdata, m_done,
        input  req_done, req_err, req_rdata, m_rd, m_wr, m_addr, m_wdata
    );
endinterface

// File: rtl/ioshim_memio_arb.sv
// Round-robin arbiter sharing the ioshim_cpu memio port between NREQ requesters,
// with registered port drive and a watchdog that aborts hung transfers.
module ioshim_memio_arb #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    ioshim_memio_arb_if.master  bus,
    output logic                busy
);
    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]       state;
    logic [PTR_W-1:0] rr;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] owner_next;
    logic [15:0]      wd;
    logic [NREQ-1:0]  active;
    logic             found;
    logic [PTR_W-1:0] pick;
    logic [1:0]       pick_wr;
    int unsigned      cand;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            active[i] = bus.req_rd[i] | (|bus.req_wr[2*i +: 2]);
        end
    end

    // First active index at or after rr, scanning with wrap-around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = int'(rr) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!found && active[cand]) begin
                found = 1'b1;
                pick  = PTR_W'(cand);
            end
        end
    end

    assign pick_wr    = bus.req_wr[2*pick +: 2];
    assign owner_next = (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;
    assign busy       = (state == GRANT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rr            <= '0;
            owner         <= '0;
            wd            <= '0;
            bus.m_rd      <= 1'b0;
            bus.m_wr      <= '0;
            bus.m_addr    <= '0;
            bus.m_wdata   <= '0;
            bus.req_done  <= '0;
            bus.req_err   <= '0;
            bus.req_rdata <= '0;
        end else begin
            bus.req_done <= '0;
            bus.req_err  <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        bus.m_addr  <= bus.req_addr[11*pick +: 11];
                        bus.m_wdata <= bus.req_wdata[16*pick +: 16];
                        bus.m_wr    <= pick_wr;
                        bus.m_rd    <= bus.req_rd[pick] & ~(|pick_wr);
                        owner       <= pick;
                        wd          <= '0;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    if (wd != '1) wd <= wd + 16'd1;
                    // Completion takes priority over a coincident watchdog expiry.
                    if (bus.m_done) begin
                        bus.req_done[owner] <= 1'b1;
                        if (bus.m_rd) bus.req_rdata <= bus.m_rdata;
                        bus.m_rd <= 1'b0;
                        bus.m_wr <= '0;
                        rr       <= owner_next;
                        state    <= IDLE;
                    end else if (wd == 16'(TIMEOUT - 1)) begin
                        bus.req_err[owner] <= 1'b1;
                        bus.m_rd <= 1'b0;
                        bus.m_wr <= '0;
                        rr       <= owner_next;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ioshim_memio_arb.sv
// Directed bench for ioshim_memio_arb (NREQ=2, TIMEOUT=8); expected values hand-computed.
module tb_ioshim_memio_arb;
    logic clk;
    logic reset;
    logic busy;
    int   vectors;
    int   miscompares;

    ioshim_memio_arb_if #(.NREQ(2)) bus ();

    ioshim_memio_arb #(.NREQ(2), .TIMEOUT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        vectors++;
        if ({bus.m_rd, bus.m_wr, bus.m_addr, bus.m_wdata} !== 30'h0) begin
            miscompares++;
            $display("FAIL reset_port got rd=%b wr=%b addr=%h wdata=%h exp all 0",
                     bus.m_rd, bus.m_wr, bus.m_addr, bus.m_wdata);
        end
        vectors++;
        if ({bus.req_done, bus.req_err, bus.req_rdata, busy} !== 21'h0) begin
            miscompares++;
            $display("FAIL reset_out got done=%b err=%b rdata=%h busy=%b exp all 0",
                     bus.req_done, bus.req_err, bus.req_rdata, busy);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        logic [1:0]  exp_wr;
        logic [15:0] exp_wd;
        logic [10:0] exp_ad;
        bus.req_wr         = 4'b0111;
        bus.req_addr[10:0] = 11'h010;
        bus.req_addr[21:11]= 11'h020;
        bus.req_wdata      = {16'h5555, 16'hAAAA};
        for (int k = 0; k < 4; k++) begin
            exp_wr = (k % 2 == 0) ? 2'b11 : 2'b01;
            exp_wd = (k % 2 == 0) ? 16'hAAAA : 16'h5555;
            exp_ad = (k % 2 == 0) ? 11'h010 : 11'h020;
            tick();
            vectors++;
            if (busy !== 1'b1 || bus.m_wr !== exp_wr || bus.m_wdata !== exp_wd ||
                bus.m_addr !== exp_ad || bus.m_rd !== 1'b0) begin
                miscompares++;
                $display("FAIL cont_grant%0d got busy=%b wr=%b wdata=%h addr=%h rd=%b exp 1 %b %h %h 0",
                         k, busy, bus.m_wr, bus.m_wdata, bus.m_addr, bus.m_rd, exp_wr, exp_wd, exp_ad);
            end
            bus.m_done = 1'b1;
            tick();
            bus.m_done = 1'b0;
            vectors++;
            if (bus.req_done !== ((k % 2 == 0) ? 2'b01 : 2'b10) || bus.req_err !== 2'b00 ||
                busy !== 1'b0 || bus.m_wr !== 2'b00) begin
                miscompares++;
                $display("FAIL cont_done%0d got done=%b err=%b busy=%b wr=%b exp done=%b err=00 busy=0 wr=00",
                         k, bus.req_done, bus.req_err, busy, bus.m_wr, (k % 2 == 0) ? 2'b01 : 2'b10);
            end
        end
        bus.req_wr = 4'b0000;
        tick();
        vectors++;
        if (busy !== 1'b0 || bus.req_done !== 2'b00) begin
            miscompares++;
            $display("FAIL cont_idle got busy=%b done=%b exp 0 00", busy, bus.req_done);
        end
    endtask

    task automatic test_single_read();
        bus.req_rd         = 2'b01;
        bus.req_addr[10:0] = 11'h123;
        tick();
        vectors++;
        if (bus.m_rd !== 1'b1 || bus.m_addr !== 11'h123 || bus.m_wr !== 2'b00 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL read_grant got rd=%b addr=%h wr=%b busy=%b exp 1 123 00 1",
                     bus.m_rd, bus.m_addr, bus.m_wr, busy);
        end
        tick();
        tick();
        bus.m_done  = 1'b1;
        bus.m_rdata = 16'hBEEF;
        tick();
        bus.m_done = 1'b0;
        bus.req_rd = 2'b00;
        vectors++;
        if (bus.req_done !== 2'b01 || bus.req_rdata !== 16'hBEEF || bus.m_rd !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL read_done got done=%b rdata=%h rd=%b busy=%b exp 01 beef 0 0",
                     bus.req_done, bus.req_rdata, bus.m_rd, busy);
        end
        tick();
        vectors++;
        if (bus.req_done !== 2'b00 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL read_pulse_once got done=%b busy=%b exp 00 0", bus.req_done, busy);
        end
    endtask

    task automatic test_rd_wr_same();
        bus.req_rd          = 2'b10;
        bus.req_wr          = 4'b1000;
        bus.req_addr[21:11] = 11'h055;
        bus.req_wdata[31:16]= 16'h9A00;
        tick();
        vectors++;
        if (bus.m_wr !== 2'b10 || bus.m_rd !== 1'b0 || bus.m_addr !== 11'h055 || bus.m_wdata !== 16'h9A00) begin
            miscompares++;
            $display("FAIL rdwr_grant got wr=%b rd=%b addr=%h wdata=%h exp 10 0 055 9a00",
                     bus.m_wr, bus.m_rd, bus.m_addr, bus.m_wdata);
        end
        bus.m_done  = 1'b1;
        bus.m_rdata = 16'h1234;
        bus.req_rd  = 2'b00;
        bus.req_wr  = 4'b0000;
        tick();
        bus.m_done = 1'b0;
        vectors++;
        if (bus.req_done !== 2'b10 || bus.req_rdata !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL rdwr_done got done=%b rdata=%h exp 10 beef", bus.req_done, bus.req_rdata);
        end
    endtask

    task automatic test_watchdog();
        bus.req_rd          = 2'b11;
        bus.req_addr[10:0]  = 11'h0AA;
        bus.req_addr[21:11] = 11'h0BB;
        tick();
        vectors++;
        if (bus.m_rd !== 1'b1 || bus.m_addr !== 11'h0AA) begin
            miscompares++;
            $display("FAIL wd_grant got rd=%b addr=%h exp 1 0aa", bus.m_rd, bus.m_addr);
        end
        for (int c = 1; c < 8; c++) begin
            tick();
            vectors++;
            if (bus.req_err !== 2'b00 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL wd_wait%0d got err=%b busy=%b exp 00 1", c, bus.req_err, busy);
            end
        end
        tick();
        bus.req_rd = 2'b10;
        vectors++;
        if (bus.req_err !== 2'b01 || bus.req_done !== 2'b00 || bus.m_rd !== 1'b0 ||
            bus.m_wr !== 2'b00 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL wd_abort got err=%b done=%b rd=%b wr=%b busy=%b exp 01 00 0 00 0",
                     bus.req_err, bus.req_done, bus.m_rd, bus.m_wr, busy);
        end
        tick();
        vectors++;
        if (bus.m_rd !== 1'b1 || bus.m_addr !== 11'h0BB || busy !== 1'b1 || bus.req_err !== 2'b00) begin
            miscompares++;
            $display("FAIL wd_next got rd=%b addr=%h busy=%b err=%b exp 1 0bb 1 00",
                     bus.m_rd, bus.m_addr, busy, bus.req_err);
        end
        bus.m_done  = 1'b1;
        bus.m_rdata = 16'h7777;
        bus.req_rd  = 2'b00;
        tick();
        bus.m_done = 1'b0;
        vectors++;
        if (bus.req_done !== 2'b10 || bus.req_rdata !== 16'h7777) begin
            miscompares++;
            $display("FAIL wd_next_done got done=%b rdata=%h exp 10 7777", bus.req_done, bus.req_rdata);
        end
    endtask

    task automatic test_addr_hold();
        bus.req_rd         = 2'b01;
        bus.req_addr[10:0] = 11'h111;
        tick();
        bus.req_addr[10:0] = 11'h222;
        bus.req_wr         = 4'b0011;
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++;
            if (bus.m_addr !== 11'h111 || bus.m_rd !== 1'b1 || bus.m_wr !== 2'b00) begin
                miscompares++;
                $display("FAIL hold%0d got addr=%h rd=%b wr=%b exp 111 1 00", c, bus.m_addr, bus.m_rd, bus.m_wr);
            end
        end
        bus.m_done  = 1'b1;
        bus.m_rdata = 16'h4242;
        bus.req_rd  = 2'b00;
        bus.req_wr  = 4'b0000;
        tick();
        bus.m_done = 1'b0;
        vectors++;
        if (bus.req_done !== 2'b01 || bus.req_rdata !== 16'h4242) begin
            miscompares++;
            $display("FAIL hold_done got done=%b rdata=%h exp 01 4242", bus.req_done, bus.req_rdata);
        end
    endtask

    task automatic test_reset_mid();
        bus.req_wr           = 4'b1100;
        bus.req_addr[21:11]  = 11'h3FF;
        bus.req_wdata[31:16] = 16'hCAFE;
        tick();
        vectors++;
        if (busy !== 1'b1 || bus.m_wr !== 2'b11 || bus.m_addr !== 11'h3FF) begin
            miscompares++;
            $display("FAIL rst_mid_grant got busy=%b wr=%b addr=%h exp 1 11 3ff", busy, bus.m_wr, bus.m_addr);
        end
        reset = 1'b1;
        tick();
        vectors++;
        if ({bus.m_rd, bus.m_wr, bus.m_addr, bus.m_wdata} !== 30'h0 ||
            {bus.req_done, bus.req_err, bus.req_rdata, busy} !== 21'h0) begin
            miscompares++;
            $display("FAIL rst_mid got rd=%b wr=%b addr=%h wdata=%h done=%b err=%b rdata=%h busy=%b exp all 0",
                     bus.m_rd, bus.m_wr, bus.m_addr, bus.m_wdata, bus.req_done, bus.req_err, bus.req_rdata, busy);
        end
        reset      = 1'b0;
        bus.req_wr = 4'b0000;
        bus.m_done = 1'b1;
        tick();
        bus.m_done = 1'b0;
        vectors++;
        if (bus.req_done !== 2'b00 || bus.req_err !== 2'b00 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_spurious got done=%b err=%b busy=%b exp 00 00 0", bus.req_done, bus.req_err, busy);
        end
        bus.req_rd          = 2'b11;
        bus.req_addr[10:0]  = 11'h001;
        bus.req_addr[21:11] = 11'h002;
        tick();
        vectors++;
        if (bus.m_addr !== 11'h001 || bus.m_rd !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_rr got addr=%h rd=%b exp 001 1", bus.m_addr, bus.m_rd);
        end
        bus.m_done  = 1'b1;
        bus.m_rdata = 16'h0F0F;
        bus.req_rd  = 2'b00;
        tick();
        bus.m_done = 1'b0;
        vectors++;
        if (bus.req_done !== 2'b01 || bus.req_rdata !== 16'h0F0F) begin
            miscompares++;
            $display("FAIL rst_rr_done got done=%b rdata=%h exp 01 0f0f", bus.req_done, bus.req_rdata);
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b1;
        bus.req_rd    = '0;
        bus.req_wr    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.m_rdata   = '0;
        bus.m_done    = 1'b0;
        test_reset();
        test_contention();
        test_single_read();
        test_rd_wr_same();
        test_watchdog();
        test_addr_hold();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
